// File: rtl/writeback_port_arbiter_pkg.sv
// Shared types and helpers for the register-file writeback port arbiter.
package writeback_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned WB_XLEN    = 32;

  // Canonical writeback request at the default datapath width.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]    data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_MEM,
    SEL_FIFO,
    SEL_BYPASS
  } wb_sel_e;

  // x0 never maps to a mask bit, so bit 0 of any OR of these stays 0.
  function automatic logic [NUM_REGS-1:0] onehot_rd(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (rd != '0) m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/writeback_port_arbiter_wb_result_fifo.sv
// In-order circular buffer for ALU results that lost the write port.
// Entries are exposed oldest-first; data view only with WB_ARB_FORWARD_EN.
module wb_result_fifo
  import writeback_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [REG_ADDR_W-1:0] push_rd_i,
  input  logic [XLEN-1:0]       push_data_i,
  output logic [CNT_W-1:0]      count_o,
  output logic [REG_ADDR_W-1:0] head_rd_o,
  output logic [XLEN-1:0]       head_data_o,
  output logic [DEPTH-1:0]      ent_valid_o,
`ifdef WB_ARB_FORWARD_EN
  output logic [XLEN-1:0]       ent_data_o [DEPTH],
`endif
  output logic [REG_ADDR_W-1:0] ent_rd_o [DEPTH]
);

  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q;
  logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
  logic [XLEN-1:0]       data_q [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        rd_q[tail_q]   <= push_rd_i;
        data_q[tail_q] <= push_data_i;
        tail_q         <= tail_q + 1'b1;
      end
      if (pop_i) head_q <= head_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (pop_i && !push_i) count_q <= count_q - 1'b1;
    end
  end

  assign count_o     = count_q;
  assign head_rd_o   = rd_q[head_q];
  assign head_data_o = data_q[head_q];

  // Age-ordered view: index 0 is the head, higher indices are younger.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      ent_valid_o[k] = CNT_W'(k) < count_q;
      ent_rd_o[k]    = rd_q[head_q + PTR_W'(k)];
`ifdef WB_ARB_FORWARD_EN
      ent_data_o[k]  = data_q[head_q + PTR_W'(k)];
`endif
    end
  end

endmodule

// File: rtl/writeback_port_arbiter.sv
// Arbitrates the single register-file write port between load responses
// (always win) and ALU results (buffered on conflict). Optional: WB_ARB_FORWARD_EN.
module writeback_port_arbiter
  import writeback_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  ex_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata,
`ifdef WB_ARB_FORWARD_EN
  input  logic [REG_ADDR_W-1:0] fwd_rs,
  output logic                  fwd_hit,
  output logic [XLEN-1:0]       fwd_data,
`endif
  output logic [NUM_REGS-1:0]   pending_mask
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]      count;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic [DEPTH-1:0]      ent_valid;
  logic [REG_ADDR_W-1:0] ent_rd [DEPTH];
`ifdef WB_ARB_FORWARD_EN
  logic [XLEN-1:0]       ent_data [DEPTH];
`endif

  logic                  full, alu_acc, mem_act;
  logic                  push, pop;
  wb_sel_e               sel;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
  logic [NUM_REGS-1:0]   mask;

  wb_result_fifo #(
    .DEPTH(DEPTH),
    .XLEN (XLEN)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push),
    .pop_i      (pop),
    .push_rd_i  (alu_rd),
    .push_data_i(alu_data),
    .count_o    (count),
    .head_rd_o  (head_rd),
    .head_data_o(head_data),
    .ent_valid_o(ent_valid),
`ifdef WB_ARB_FORWARD_EN
    .ent_data_o (ent_data),
`endif
    .ent_rd_o   (ent_rd)
  );

  // Stall depends only on the registered occupancy.
  assign full     = (count == CNT_W'(DEPTH));
  assign ex_stall = full;
  assign alu_acc  = alu_valid && !full && (alu_rd != '0);
  assign mem_act  = mem_valid && (mem_rd != '0);

  always_comb begin
    sel  = SEL_NONE;
    push = 1'b0;
    pop  = 1'b0;
    if (mem_act) begin
      sel  = SEL_MEM;
      push = alu_acc;
    end else if (count != '0) begin
      sel  = SEL_FIFO;
      pop  = 1'b1;
      push = alu_acc;
    end else if (alu_acc) begin
      sel  = SEL_BYPASS;
    end
  end

  always_comb begin
    rf_we_d    = (sel != SEL_NONE);
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    case (sel)
      SEL_MEM: begin
        rf_rd_d    = mem_rd;
        rf_wdata_d = mem_data;
      end
      SEL_FIFO: begin
        rf_rd_d    = head_rd;
        rf_wdata_d = head_data;
      end
      SEL_BYPASS: begin
        rf_rd_d    = alu_rd;
        rf_wdata_d = alu_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

  // Decoded from FIFO flops, so it reflects buffer contents after each edge.
  always_comb begin
    mask = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (ent_valid[k]) mask = mask | onehot_rd(ent_rd[k]);
    end
  end

  assign pending_mask = mask;

`ifdef WB_ARB_FORWARD_EN
  // Scan oldest to youngest so the youngest match is left standing.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (ent_valid[k] && (ent_rd[k] == fwd_rs) && (fwd_rs != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_port_arbiter.sv
// Scoreboard bench for writeback_port_arbiter; a queue-based reference model
// predicts every register-file write, checked by a negedge monitor.
module tb_writeback_port_arbiter;
  import writeback_port_arbiter_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned XLEN  = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            alu_valid = 1'b0;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            mem_valid = 1'b0;
  logic [4:0]      mem_rd = '0;
  logic [XLEN-1:0] mem_data = '0;
  logic            ex_stall, rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     pending_mask;
`ifdef WB_ARB_FORWARD_EN
  logic [4:0]      fwd_rs = '0;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;
`endif

  int unsigned checks = 0;
  int unsigned passed = 0;

  wb_req_t mq[$];    // model of buffered ALU writes
  wb_req_t expq[$];  // expected register-file writes, in order
  wb_req_t mon_e;

  writeback_port_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .ex_stall(ex_stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
`ifdef WB_ARB_FORWARD_EN
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .pending_mask(pending_mask)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  always @(negedge clock) begin
    if (rf_we === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        $display("FAIL sb_unexpected: got write x%0d=%h, required no write", rf_rd, rf_wdata);
      end else begin
        mon_e = expq.pop_front();
        if (rf_rd !== mon_e.rd || rf_wdata !== mon_e.data)
          $display("FAIL sb_write: got x%0d=%h, required x%0d=%h", rf_rd, rf_wdata, mon_e.rd, mon_e.data);
        else passed++;
      end
    end else if (rf_we !== 1'b0) begin
      checks++;
      $display("FAIL sb_we_unknown: got rf_we=%b, required 0 or 1", rf_we);
    end
  end

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) m = m | onehot_rd(mq[i].rd);
    return m;
  endfunction

  // Drive one cycle of stimulus, advance the model, return at posedge+1.
  task automatic cycle(input logic rst, input logic av, input logic [4:0] ard,
                       input logic [31:0] ad, input logic mv, input logic [4:0] mrd,
                       input logic [31:0] md);
    wb_req_t a, r;
    logic stall, acc, mact;
    reset = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    a.valid = 1'b1; a.rd = ard; a.data = ad;
    if (rst) begin
      mq.delete();
    end else begin
      stall = (mq.size() == DEPTH);
      acc   = av && !stall && (ard != 5'd0);
      mact  = mv && (mrd != 5'd0);
      if (mact) begin
        r.valid = 1'b1; r.rd = mrd; r.data = md;
        expq.push_back(r);
        if (acc) mq.push_back(a);
      end else if (mq.size() > 0) begin
        r = mq.pop_front();
        expq.push_back(r);
        if (acc) mq.push_back(a);
      end else if (acc) begin
        expq.push_back(a);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66);
      checks++; if (rf_we !== 1'b0) $display("FAIL reset_we: got %b required 0", rf_we); else passed++;
      checks++; if (ex_stall !== 1'b0) $display("FAIL reset_stall: got %b required 0", ex_stall); else passed++;
      checks++; if (pending_mask !== 32'h0) $display("FAIL reset_mask: got %h required 0", pending_mask); else passed++;
      checks++; if (rf_rd !== 5'd0 || rf_wdata !== 32'h0)
        $display("FAIL reset_rf: got x%0d=%h required x0=0", rf_rd, rf_wdata); else passed++;
    end
`ifdef WB_ARB_FORWARD_EN
    fwd_rs = 5'd5; #1;
    checks++; if (fwd_hit !== 1'b0) $display("FAIL reset_fwd: got %b required 0", fwd_hit); else passed++;
    fwd_rs = 5'd0;
`endif
  endtask

  task automatic test_bypass();
    cycle(1'b0, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'h11)
      $display("FAIL bypass_write: got we=%b x%0d=%h required we=1 x5=11", rf_we, rf_rd, rf_wdata); else passed++;
    checks++; if (pending_mask !== 32'h0 || ex_stall !== 1'b0)
      $display("FAIL bypass_empty: got mask=%h stall=%b required 0/0", pending_mask, ex_stall); else passed++;
    idle(1);
    checks++; if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_wdata !== 32'h11)
      $display("FAIL bypass_hold: got we=%b x%0d=%h required we=0 x5=11", rf_we, rf_rd, rf_wdata); else passed++;
  endtask

  task automatic test_conflict();
    cycle(1'b0, 1'b1, 5'd4, 32'hBB, 1'b1, 5'd3, 32'hAA);
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'hAA)
      $display("FAIL conflict_mem: got we=%b x%0d=%h required x3=aa", rf_we, rf_rd, rf_wdata); else passed++;
    checks++; if (pending_mask !== 32'h10) $display("FAIL conflict_mask: got %h required 00000010", pending_mask); else passed++;
`ifdef WB_ARB_FORWARD_EN
    fwd_rs = 5'd4; #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hBB)
      $display("FAIL conflict_fwd: got hit=%b data=%h required 1/bb", fwd_hit, fwd_data); else passed++;
    fwd_rs = 5'd0;
`endif
    idle(1);
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_wdata !== 32'hBB)
      $display("FAIL conflict_alu: got we=%b x%0d=%h required x4=bb", rf_we, rf_rd, rf_wdata); else passed++;
    checks++; if (pending_mask !== 32'h0) $display("FAIL conflict_drained: got %h required 0", pending_mask); else passed++;
  endtask

  task automatic test_full();
    logic [31:0] exp_mask [6] = '{32'h2, 32'h6, 32'h6, 32'h4, 32'h8, 32'h0};
    logic        exp_stl  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    cycle(1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd8,  32'hC8);
    checks++; if (ex_stall !== exp_stl[0] || pending_mask !== exp_mask[0])
      $display("FAIL full_c1: got stall=%b mask=%h required %b/%h", ex_stall, pending_mask, exp_stl[0], exp_mask[0]); else passed++;
    cycle(1'b0, 1'b1, 5'd2, 32'hA2, 1'b1, 5'd9,  32'hC9);
    checks++; if (ex_stall !== exp_stl[1] || pending_mask !== exp_mask[1])
      $display("FAIL full_c2: got stall=%b mask=%h required %b/%h", ex_stall, pending_mask, exp_stl[1], exp_mask[1]); else passed++;
    cycle(1'b0, 1'b1, 5'd3, 32'hA3, 1'b1, 5'd10, 32'hCA);
    checks++; if (ex_stall !== exp_stl[2] || pending_mask !== exp_mask[2])
      $display("FAIL full_c3: got stall=%b mask=%h required %b/%h", ex_stall, pending_mask, exp_stl[2], exp_mask[2]); else passed++;
    cycle(1'b0, 1'b1, 5'd3, 32'hA3, 1'b0, 5'd0, 32'h0);
    checks++; if (ex_stall !== exp_stl[3] || pending_mask !== exp_mask[3] || rf_rd !== 5'd1)
      $display("FAIL full_c4: got stall=%b mask=%h rd=%0d required %b/%h/1", ex_stall, pending_mask, rf_rd, exp_stl[3], exp_mask[3]); else passed++;
    cycle(1'b0, 1'b1, 5'd3, 32'hA3, 1'b0, 5'd0, 32'h0);
    checks++; if (ex_stall !== exp_stl[4] || pending_mask !== exp_mask[4] || rf_rd !== 5'd2)
      $display("FAIL full_c5: got stall=%b mask=%h rd=%0d required %b/%h/2", ex_stall, pending_mask, rf_rd, exp_stl[4], exp_mask[4]); else passed++;
    idle(1);
    checks++; if (ex_stall !== exp_stl[5] || pending_mask !== exp_mask[5] || rf_rd !== 5'd3 || rf_wdata !== 32'hA3)
      $display("FAIL full_c6: got stall=%b mask=%h x%0d=%h required 0/0/x3=a3", ex_stall, pending_mask, rf_rd, rf_wdata); else passed++;
    idle(1);
  endtask

  task automatic test_x0();
    cycle(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd0, 32'hDEAD);
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h77)
      $display("FAIL x0_mem_dropped: got we=%b x%0d=%h required x7=77", rf_we, rf_rd, rf_wdata); else passed++;
    cycle(1'b0, 1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'h0);
    checks++; if (rf_we !== 1'b0 || pending_mask !== 32'h0)
      $display("FAIL x0_alu_dropped: got we=%b mask=%h required 0/0", rf_we, pending_mask); else passed++;
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, 5'd12, 32'hB12, 1'b1, 5'd8, 32'hD8);
    cycle(1'b0, 1'b1, 5'd13, 32'hB13, 1'b1, 5'd9, 32'hD9);
    checks++; if (ex_stall !== 1'b1 || pending_mask !== 32'h3000)
      $display("FAIL rmid_filled: got stall=%b mask=%h required 1/00003000", ex_stall, pending_mask); else passed++;
    cycle(1'b1, 1'b1, 5'd14, 32'hB14, 1'b1, 5'd15, 32'hDF);
    checks++; if (ex_stall !== 1'b0 || pending_mask !== 32'h0 || rf_we !== 1'b0)
      $display("FAIL rmid_cleared: got stall=%b mask=%h we=%b required 0/0/0", ex_stall, pending_mask, rf_we); else passed++;
    for (int unsigned i = 0; i < 3; i++) begin
      idle(1);
      checks++; if (rf_we !== 1'b0) $display("FAIL rmid_stale: got we=%b x%0d required no write", rf_we, rf_rd); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    for (int unsigned i = 0; i < 200; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom);
      checks++; if (ex_stall !== (mq.size() == DEPTH) || pending_mask !== model_mask())
        $display("FAIL b2b_state: cycle %0d got stall=%b mask=%h required %b/%h",
                 i, ex_stall, pending_mask, (mq.size() == DEPTH), model_mask()); else passed++;
    end
    idle(DEPTH + 2);
  endtask

  task automatic test_drained(input string name);
    @(negedge clock);
    #1;
    checks++; if (expq.size() != 0) $display("FAIL %s_missing: got %0d writes outstanding required 0", name, expq.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_bypass();      test_drained("bypass");
    test_conflict();    test_drained("conflict");
    test_full();        test_drained("full");
    test_x0();          test_drained("x0");
    test_reset_mid();   test_drained("reset_mid");
    test_back_to_back(); test_drained("b2b");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/writeback_port_arbiter.md
Name: writeback_port_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - ALU results leaving the EX/WB pipeline registers.
  - Late load responses from the data-memory interface.
- Load responses always win the port, because memory cannot be back-pressured.
- A losing ALU write waits in a small in-order FIFO. When the FIFO is full, the block stalls EX.
- Sits between the EX/WB pipeline registers, the load unit and the register file.

Parameters:
- DEPTH, 2, number of ALU-result buffer entries; power of two, >= 2.
- XLEN, 32, data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU write request (EX/WB reg_write).
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- mem_valid  in  1  load response valid; cannot be stalled.
- mem_rd  in  5  load destination register.
- mem_data  in  XLEN  load data.
- ex_stall  out  1  high: upstream holds the EX/WB registers and re-presents the same request.
- rf_we  out  1  register-file write enable.
- rf_rd  out  5  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- pending_mask  out  32  bit r set if any buffered entry targets r; bit 0 is always 0.

Behaviour:
- Reset, synchronous: FIFO count, head and tail pointers = 0; rf_we = 0, rf_rd = 0, rf_wdata = 0; ex_stall = 0; pending_mask = 0.
- A reset mid-operation discards all buffered entries.
- ex_stall = (count == DEPTH). It is decoded from registered state only, with no path from inputs.
- ALU request accepted = alu_valid && !ex_stall && alu_rd != 0. While ex_stall is high, alu_* is ignored.
- Mem request active = mem_valid && mem_rd != 0.
- Writes to x0 from either source are dropped and consume no slot.
- Port selection each cycle, in priority order:
  1. mem active: write mem. If an ALU request was accepted, push it.
  2. count > 0: pop the FIFO head and write it. If an ALU request was accepted, push it in the same cycle; count is unchanged.
  3. ALU request accepted with an empty FIFO: bypass, write it directly with no enqueue.
  4. Otherwise rf_we = 0.
- Latency: the selected write appears on rf_* one cycle after its inputs. Outputs are registered; rf_rd and rf_wdata hold their last values while rf_we = 0.
- Full with mem active: no pop and no push; the stall persists.
- Full with no mem: pop; count = DEPTH-1, so the stall drops on the next cycle.
- Pointers wrap modulo DEPTH. count has width clog2(DEPTH)+1.
- The FIFO drains strictly in order.
- Same-rd ordering between a buffered ALU write and a newer load is enforced upstream: decode stalls on pending_mask. This block does not reorder.
- pending_mask is registered and reflects FIFO contents after the current edge.

Optional Feature:
- Macro WB_ARB_FORWARD_EN.
- Defined:
  - Adds ports fwd_rs in 5, fwd_hit out 1, fwd_data out XLEN.
  - Combinational lookup over the FIFO returns the youngest matching buffered entry.
  - fwd_hit = 0 for rs = 0 or no match.
- Undefined: the ports are absent. Decode must stall on pending_mask instead.

Decomposition:
- Shared package holds:
  - REG_ADDR_W = 5.
  - The wb_req struct {valid, rd, data}.
  - The helper function onehot_rd(rd) -> 32-bit mask.
- Natural sub-module: wb_result_fifo.
  - Parameterised DEPTH circular buffer with push/pop/count.
  - Exposes the entry array for pending_mask and forwarding.
- Arbitration and output registers stay in the top.

Test Plan:
1. Reset held with alu_valid = 1 -> rf_we = 0, ex_stall = 0, pending_mask = 0 for every reset cycle.
2. Bypass: empty FIFO, alu (rd = 5, data = 0x11) -> next cycle rf_we = 1, rf_rd = 5, rf_wdata = 0x11; count remains 0.
3. Conflict: same cycle mem (rd = 3, 0xAA) and alu (rd = 4, 0xBB) -> cycle+1 writes x3 = 0xAA; cycle+2 writes x4 = 0xBB; pending_mask = 0x10 between those cycles.
4. Full: DEPTH = 2, three consecutive cycles of alu plus mem -> ex_stall high after the second push. The held alu request is accepted only after mem drops. All writes arrive in order with no loss or duplication.
5. x0: mem_valid with rd = 0 and alu rd = 7 in the same cycle -> alu bypasses to x7; there is no mem write.
6. Reset mid-operation: FIFO holding 2 entries, reset pulse -> count = 0, pending_mask = 0, and no stale write after reset release.
